// File: rtl/ahb_pkg.sv
// Shared AHB definitions: transfer/response codes and slave state encoding.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;
    localparam logic [1:0] HRESP_RETRY = 2'b10;
    localparam logic [1:0] HRESP_SPLIT = 2'b11;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP,
        ST_ERR1,
        ST_ERR2,
        ST_RTY1,
        ST_RTY2,
        ST_SPL1,
        ST_SPL2
    } state_e;

    // A transfer is rejected when it is wider than the data bus or not
    // naturally aligned. hsize tops out at 7 (128 bytes), so only the low
    // seven address bits matter for alignment.
    function automatic logic xfer_bad(input logic [6:0] addr_lsb,
                                      input logic [2:0] size,
                                      input int         max_size);
        logic [6:0] mask;
        mask = 7'((8'd1 << size) - 8'd1);
        return (int'(size) > max_size) || ((addr_lsb & mask) != 7'd0);
    endfunction

endpackage

// File: rtl/ahb_slave_if_param_if.sv
// AHB bus-side signal bundle for one slave slot.
interface ahb_slave_if_param_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_MASTERS = 4
);
    localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    logic                   hsel;
    logic [ADDR_WIDTH-1:0]  haddr;
    logic                   hwrite;
    logic [1:0]             htrans;
    logic [2:0]             hsize;
    logic [DATA_WIDTH-1:0]  hwdata;
    logic [MW-1:0]          hmaster;
    logic                   hreadyin;
    logic                   hreadyout;
    logic [1:0]             hresp;
    logic [DATA_WIDTH-1:0]  hrdata;
    logic [NUM_MASTERS-1:0] hsplit;

    modport master (
        output hsel, haddr, hwrite, htrans, hsize, hwdata, hmaster, hreadyin,
        input  hreadyout, hresp, hrdata, hsplit
    );

    modport slave (
        input  hsel, haddr, hwrite, htrans, hsize, hwdata, hmaster, hreadyin,
        output hreadyout, hresp, hrdata, hsplit
    );

endinterface

// File: rtl/ahb_split_tracker.sv
// Remembers which masters were split and pulses hsplit when the backend
// says they may retry.
module ahb_split_tracker #(
    parameter int NUM_MASTERS = 4,
    parameter int MW          = 2
) (
    input  logic                   hclk,
    input  logic                   hresetn,
    input  logic                   set_en,
    input  logic [MW-1:0]          set_idx,
    input  logic                   done,
    output logic [NUM_MASTERS-1:0] hsplit
);

    logic [NUM_MASTERS-1:0] mask_q;
    logic [NUM_MASTERS-1:0] set_vec;

    assign set_vec = set_en ? (NUM_MASTERS'(1) << set_idx) : '0;

    // A split arriving together with done lands in the fresh mask and is
    // not part of the resume pulse.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            mask_q <= '0;
            hsplit <= '0;
        end else begin
            hsplit <= done ? mask_q : '0;
            mask_q <= done ? set_vec : (mask_q | set_vec);
        end
    end

endmodule

// File: rtl/ahb_slave_if_param.sv
// AHB slave bridge: address/data phase pipelining, backend wait states,
// two-cycle ERROR/RETRY/SPLIT responses and split-master tracking.
module ahb_slave_if_param
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_MASTERS = 4,
    parameter int MAX_WAIT    = 16
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    ahb_slave_if_param_if.slave   bus,
    output logic                  be_valid,
    output logic                  be_write,
    output logic [ADDR_WIDTH-1:0] be_addr,
    output logic [DATA_WIDTH-1:0] be_wdata,
    input  logic                  be_ready,
    input  logic [DATA_WIDTH-1:0] be_rdata,
    input  logic                  be_error,
    input  logic                  be_split,
    input  logic                  be_split_done
);

    localparam int MW       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int MAX_SIZE = $clog2(DATA_WIDTH / 8);
    localparam int TW       = $clog2(MAX_WAIT + 2);

    state_e          state_q, state_d;
    logic [MW-1:0]   master_q;
    logic [TW-1:0]   timer_q;
    logic            can_accept, accept, bad, timeout, split_set;
    logic            hready;
    logic [1:0]      hresp;

    // New address phases are only taken while the previous transfer is
    // finishing (or nothing is in flight).
    assign can_accept = (state_q == ST_IDLE) || (state_q == ST_RESP) ||
                        (state_q == ST_ERR2) || (state_q == ST_RTY2) ||
                        (state_q == ST_SPL2);
    assign accept  = can_accept && bus.hsel && bus.hreadyin &&
                     (bus.htrans == HTRANS_NONSEQ || bus.htrans == HTRANS_SEQ);
    assign bad     = xfer_bad(bus.haddr[6:0], bus.hsize, MAX_SIZE);
    // timer holds the number of the current ACCESS cycle (first cycle = 1).
    assign timeout = (MAX_WAIT > 0) && (timer_q == TW'(MAX_WAIT)) && !be_ready;

    assign bus.hreadyout = hready;
    assign bus.hresp     = hresp;
    assign be_wdata      = (state_q == ST_ACCESS && be_write) ? bus.hwdata : '0;

    // Next state and per-state bus/backend outputs.
    always_comb begin
        state_d   = state_q;
        hready    = 1'b1;
        hresp     = HRESP_OKAY;
        be_valid  = 1'b0;
        split_set = 1'b0;
        unique case (state_q)
            ST_ACCESS: begin
                hready   = 1'b0;
                be_valid = 1'b1;
                if (be_ready) begin
                    if (be_split) begin
                        state_d   = ST_SPL1;
                        split_set = 1'b1;
                    end else if (be_error) begin
                        state_d = ST_ERR1;
                    end else begin
                        state_d = ST_RESP;
                    end
                end else if (timeout) begin
                    state_d = ST_RTY1;
                end
            end
            ST_ERR1: begin hready = 1'b0; hresp = HRESP_ERROR; state_d = ST_ERR2; end
            ST_RTY1: begin hready = 1'b0; hresp = HRESP_RETRY; state_d = ST_RTY2; end
            ST_SPL1: begin hready = 1'b0; hresp = HRESP_SPLIT; state_d = ST_SPL2; end
            default: begin
                if (state_q == ST_ERR2) hresp = HRESP_ERROR;
                if (state_q == ST_RTY2) hresp = HRESP_RETRY;
                if (state_q == ST_SPL2) hresp = HRESP_SPLIT;
                if (accept) state_d = bad ? ST_ERR1 : ST_ACCESS;
                else        state_d = ST_IDLE;
            end
        endcase
    end

    // State, address-phase capture, wait timer and read data register.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q    <= ST_IDLE;
            master_q   <= '0;
            timer_q    <= '0;
            be_addr    <= '0;
            be_write   <= 1'b0;
            bus.hrdata <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                be_addr  <= bus.haddr;
                be_write <= bus.hwrite;
                master_q <= bus.hmaster;
            end
            if (state_d == ST_ACCESS)
                timer_q <= (state_q != ST_ACCESS) ? TW'(1) :
                           (timer_q == TW'(MAX_WAIT)) ? timer_q : timer_q + TW'(1);
            else
                timer_q <= '0;
            if (state_q == ST_ACCESS && be_ready && !be_split && !be_error && !be_write)
                bus.hrdata <= be_rdata;
        end
    end

    ahb_split_tracker #(
        .NUM_MASTERS (NUM_MASTERS),
        .MW          (MW)
    ) u_split (
        .hclk    (hclk),
        .hresetn (hresetn),
        .set_en  (split_set),
        .set_idx (master_q),
        .done    (be_split_done),
        .hsplit  (bus.hsplit)
    );

endmodule
